spi_ram_burst: RTL and testbench

- Parametrised command-decoded RAM slave behind the SPI serial-to-parallel front end.
- Accepts {cmd[1:0], payload} words on rx_valid and implements four commands: write-address, write-data, read-address and read-data.
- Adds over the previous generation:
  - configurable data and address widths;
  - optional address auto-increment for burst transfers;
  - a sequential post-reset memory clear with a ready flag;
  - an error flag for out-of-range addresses and dropped commands.

---
 rtl/spi_ram_burst_if.sv | 21 ++
 rtl/spi_ram_burst.sv | 143 ++++++++++++++
 tb/tb_spi_ram_burst.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_burst_if.sv
// Command/response bundle between the SPI front end and the RAM slave.
interface spi_ram_burst_if #(
  parameter int DATA_W = 8
);
  logic              rx_valid;
  logic [DATA_W+1:0] din;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              ready;
  logic              err;

  modport master (
    output rx_valid, din,
    input  dout, tx_valid, ready, err
  );

  modport slave (
    input  rx_valid, din,
    output dout, tx_valid, ready, err
  );
endinterface

// File: rtl/spi_ram_burst.sv
// Command-decoded RAM slave: write/read address and data commands,
// optional address auto-increment, sequential clear after reset.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zeroing mem[clr_cnt] one word per cycle, commands rejected
// ST_IDLE  | clear done, ready=1, commands decoded on rx_valid
module spi_ram_burst #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_ram_burst_if.slave  bus
);

  localparam int              LAST_I  = MEM_DEPTH - 1;
  localparam logic [ADDR_W-1:0] LAST  = LAST_I[ADDR_W-1:0];
  localparam logic [ADDR_W:0]   DEPTH_X = MEM_DEPTH[ADDR_W:0];

  localparam logic [1:0] CMD_WA = 2'b00;
  localparam logic [1:0] CMD_WD = 2'b01;
  localparam logic [1:0] CMD_RA = 2'b10;
  localparam logic [1:0] CMD_RD = 2'b11;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];

  logic [ADDR_W-1:0] addr_wr, addr_wr_nxt;
  logic [ADDR_W-1:0] addr_rd, addr_rd_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_en;
  logic              err_nxt;

  logic [DATA_W-1:0] dout_q;
  logic              tx_q;
  logic              err_q;

  logic [1:0]        cmd;
  logic [ADDR_W-1:0] cmd_addr;
  logic              addr_ok;

  // Wrapping increment that respects non-power-of-two depths.
  function automatic logic [ADDR_W-1:0] inc_wrap(input logic [ADDR_W-1:0] a);
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction

  assign cmd      = bus.din[DATA_W+1:DATA_W];
  assign cmd_addr = bus.din[ADDR_W-1:0];
  assign addr_ok  = ({1'b0, cmd_addr} < DEPTH_X);

  // Next-state, address updates and memory write port selection.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    addr_wr_nxt = addr_wr;
    addr_rd_nxt = addr_rd;
    mem_we      = 1'b0;
    mem_waddr   = addr_wr;
    mem_wdata   = bus.din[DATA_W-1:0];
    rd_en       = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      ST_CLEAR: begin
        mem_we      = 1'b1;
        mem_waddr   = clr_cnt;
        mem_wdata   = '0;
        clr_cnt_nxt = inc_wrap(clr_cnt);
        if (clr_cnt == LAST) state_nxt = ST_IDLE;
        if (bus.rx_valid) err_nxt = 1'b1;
      end
      ST_IDLE: begin
        if (bus.rx_valid) begin
          case (cmd)
            CMD_WA: begin
              if (addr_ok) addr_wr_nxt = cmd_addr;
              else         err_nxt     = 1'b1;
            end
            CMD_WD: begin
              mem_we = 1'b1;
              if (AUTO_INC != 0) addr_wr_nxt = inc_wrap(addr_wr);
            end
            CMD_RA: begin
              if (addr_ok) addr_rd_nxt = cmd_addr;
              else         err_nxt     = 1'b1;
            end
            CMD_RD: begin
              rd_en = 1'b1;
              if (AUTO_INC != 0) addr_rd_nxt = inc_wrap(addr_rd);
            end
            default: ;
          endcase
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // State, address pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      addr_wr <= '0;
      addr_rd <= '0;
      dout_q  <= '0;
      tx_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      addr_wr <= addr_wr_nxt;
      addr_rd <= addr_rd_nxt;
      tx_q    <= rd_en;
      err_q   <= err_nxt;
      if (rd_en) dout_q <= mem[addr_rd];
    end
  end

  // Single write port shared by the clear sequencer and write-data command.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_q;
  assign bus.err      = err_q;
  assign bus.ready    = (state == ST_IDLE);

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst with read-data scoreboards on three
// parameter sets: default, depth 200, and static addressing.
module tb_spi_ram_burst;

  logic clk;
  logic rst_n;
  logic rst_n_a;

  spi_ram_burst_if #(.DATA_W(8)) ifa ();
  spi_ram_burst_if #(.DATA_W(8)) ifb ();
  spi_ram_burst_if #(.DATA_W(8)) ifc ();

  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(ifa));
  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));
  spi_ram_burst #(.DATA_W(8), .ADDR_W(4), .MEM_DEPTH(16), .AUTO_INC(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc));

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt [3];
  logic [7:0] q [3][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int s, input logic tv, input logic er, input logic [7:0] d);
    logic [7:0] e;
    if (tv) begin
      if (q[s].size() == 0) begin
        check($sformatf("dut%0d_tx_unexpected", s), 32'd1, 32'd0);
      end else begin
        e = q[s].pop_front();
        check($sformatf("dut%0d_dout", s), {24'd0, d}, {24'd0, e});
      end
    end
    if (er) err_cnt[s]++;
    if (tv || er) check($sformatf("dut%0d_err_tx_excl", s), {31'd0, tv & er}, 32'd0);
  endtask

  always @(negedge clk) begin
    mon(0, ifa.tx_valid, ifa.err, ifa.dout);
    mon(1, ifb.tx_valid, ifb.err, ifb.dout);
    mon(2, ifc.tx_valid, ifc.err, ifc.dout);
  end

  task automatic cmd(input int s, input logic [1:0] c, input logic [7:0] p);
    case (s)
      0:       begin ifa.rx_valid = 1'b1; ifa.din = {c, p}; end
      1:       begin ifb.rx_valid = 1'b1; ifb.din = {c, p}; end
      default: begin ifc.rx_valid = 1'b1; ifc.din = {c, p}; end
    endcase
    @(posedge clk);
    #1;
    ifa.rx_valid = 1'b0;
    ifb.rx_valid = 1'b0;
    ifc.rx_valid = 1'b0;
  endtask

  task automatic rd(input int s, input logic [7:0] exp);
    q[s].push_back(exp);
    cmd(s, 2'b11, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int na, nb, nc, e0;

  initial begin
    ifa.rx_valid = 1'b0; ifa.din = '0;
    ifb.rx_valid = 1'b0; ifb.din = '0;
    ifc.rx_valid = 1'b0; ifc.din = '0;
    rst_n = 1'b0;
    rst_n_a = 1'b0;
    for (int i = 0; i < 3; i++) err_cnt[i] = 0;

    idle(2);
    check("rst_dout", {24'd0, ifa.dout}, 32'd0);
    check("rst_tx_valid", {31'd0, ifa.tx_valid}, 32'd0);
    check("rst_err", {31'd0, ifa.err}, 32'd0);
    check("rst_ready", {31'd0, ifa.ready}, 32'd0);

    // Release all resets together and measure each clear length.
    @(negedge clk);
    rst_n = 1'b1;
    rst_n_a = 1'b1;
    na = 0; nb = -1; nc = -1;
    while (!ifa.ready && na < 1000) begin
      @(posedge clk);
      #1;
      na++;
      if (nb < 0 && ifb.ready) nb = na;
      if (nc < 0 && ifc.ready) nc = na;
    end
    check("clear_cycles_256", na, 256);
    check("clear_cycles_200", nb, 200);
    check("clear_cycles_16", nc, 16);

    // Freshly cleared memory reads zero.
    cmd(0, 2'b10, 8'h00);
    cmd(0, 2'b10, 8'h05);
    rd(0, 8'h00);
    rd(0, 8'h00);

    // Burst write then burst read.
    cmd(0, 2'b00, 8'h10);
    cmd(0, 2'b01, 8'hA1);
    cmd(0, 2'b01, 8'hB2);
    cmd(0, 2'b01, 8'hC3);
    cmd(0, 2'b10, 8'h10);
    rd(0, 8'hA1);
    rd(0, 8'hB2);
    rd(0, 8'hC3);

    // Wrap from the last address back to 0.
    cmd(0, 2'b00, 8'hFF);
    cmd(0, 2'b01, 8'h11);
    cmd(0, 2'b01, 8'h22);
    cmd(0, 2'b10, 8'hFF);
    rd(0, 8'h11);
    rd(0, 8'h22);
    cmd(0, 2'b10, 8'h00);
    rd(0, 8'h22);

    // Read immediately after a write to the same address.
    cmd(0, 2'b00, 8'h40);
    cmd(0, 2'b10, 8'h40);
    cmd(0, 2'b01, 8'h77);
    rd(0, 8'h77);
    idle(3);
    check("a_queue_drained", q[0].size(), 0);
    check("a_dout_holds", {24'd0, ifa.dout}, 32'h77);
    check("a_no_err_yet", err_cnt[0], 0);

    // Reset in the middle of a write burst.
    cmd(0, 2'b00, 8'h10);
    cmd(0, 2'b01, 8'hDE);
    cmd(0, 2'b01, 8'hAD);
    rst_n_a = 1'b0;
    #1;
    check("midrst_dout", {24'd0, ifa.dout}, 32'd0);
    check("midrst_tx_valid", {31'd0, ifa.tx_valid}, 32'd0);
    check("midrst_err", {31'd0, ifa.err}, 32'd0);
    check("midrst_ready", {31'd0, ifa.ready}, 32'd0);
    idle(2);
    @(negedge clk);
    rst_n_a = 1'b1;

    // A command during clear is rejected and must not land in memory.
    e0 = err_cnt[0];
    cmd(0, 2'b01, 8'hFF);
    idle(1);
    check("clear_cmd_err", err_cnt[0], e0 + 1);
    check("clear_not_ready", {31'd0, ifa.ready}, 32'd0);
    na = 2;
    while (!ifa.ready && na < 1000) begin
      @(posedge clk);
      #1;
      na++;
    end
    check("reclear_cycles_256", na, 256);
    cmd(0, 2'b10, 8'h00);
    for (int i = 0; i < 256; i++) rd(0, 8'h00);
    idle(3);
    check("a_scan_drained", q[0].size(), 0);

    // Depth 200: out-of-range address rejected, pointer kept.
    cmd(1, 2'b00, 8'h05);
    e0 = err_cnt[1];
    cmd(1, 2'b00, 8'hC8);
    idle(1);
    check("b_wa_range_err", err_cnt[1], e0 + 1);
    cmd(1, 2'b01, 8'h33);
    cmd(1, 2'b00, 8'hC7);
    cmd(1, 2'b01, 8'h5A);
    cmd(1, 2'b01, 8'h6B);
    e0 = err_cnt[1];
    cmd(1, 2'b10, 8'hC8);
    idle(1);
    check("b_ra_range_err", err_cnt[1], e0 + 1);
    cmd(1, 2'b10, 8'hC7);
    rd(1, 8'h5A);
    rd(1, 8'h6B);
    cmd(1, 2'b10, 8'h05);
    rd(1, 8'h33);
    idle(3);
    check("b_queue_drained", q[1].size(), 0);

    // Static addressing; upper payload bits above the address ignored.
    cmd(2, 2'b00, 8'h03);
    cmd(2, 2'b01, 8'hAA);
    cmd(2, 2'b01, 8'hBB);
    cmd(2, 2'b10, 8'h03);
    rd(2, 8'hBB);
    rd(2, 8'hBB);
    cmd(2, 2'b10, 8'h04);
    rd(2, 8'h00);
    cmd(2, 2'b10, 8'hF3);
    rd(2, 8'hBB);
    idle(3);
    check("c_queue_drained", q[2].size(), 0);
    check("c_no_err", err_cnt[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
